// File: rtl/maze_move_sequencer.sv
// maze_move_sequencer
// Runs one tilt-maze move per request: it validates the requested neighbour
// cell, then tilts the servo pair for that axis. It levels the maze, lets the
// ball settle, compares the sensed cell with the target and then reports
// completion with a pass/fail flag.
// Optional feature: define MOVE_RETRY_EN to retry a missed move up to
// MAX_RETRY times, re-planning from the cell the ball actually reached.
module maze_move_sequencer #(
  parameter int unsigned COLS          = 6,
  parameter int unsigned NUM_CELLS     = 36,
  parameter int unsigned NEUTRAL       = 90,
  parameter int unsigned TILT_DELTA    = 20,
  parameter int unsigned TILT_CYCLES   = 25_000_000,
  parameter int unsigned SETTLE_CYCLES = 12_500_000,
  parameter int unsigned MAX_RETRY     = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       move_req,
  input  logic [5:0] next_state,
  input  logic [5:0] maze_state,
  output logic [7:0] angle1,
  output logic [7:0] angle2,
  output logic [7:0] angle3,
  output logic [7:0] angle4,
  output logic       busy,
  output logic       move_complete,
  output logic       move_fail
);

  typedef enum logic [2:0] {S_IDLE, S_CHECK, S_TILT, S_LEVEL, S_VERIFY, S_DONE} state_e;
  typedef enum logic [2:0] {DIR_NONE, DIR_E, DIR_W, DIR_S, DIR_N} dir_e;

  localparam logic [7:0]  ANG_MID     = 8'(NEUTRAL);
  localparam logic [7:0]  ANG_HI      = 8'(NEUTRAL + TILT_DELTA);
  localparam logic [7:0]  ANG_LO      = 8'(NEUTRAL - TILT_DELTA);
  localparam logic [31:0] TILT_LAST   = 32'(TILT_CYCLES - 1);
  localparam logic [31:0] SETTLE_LAST = 32'(SETTLE_CYCLES - 1);
  localparam logic [6:0]  COLS_W      = 7'(COLS);
  localparam logic [5:0]  LAST_COL    = 6'(COLS - 1);

  // The retry counter is two bits wide and the angle maths must not wrap.
  if (NEUTRAL + TILT_DELTA > 180 || NEUTRAL < TILT_DELTA || MAX_RETRY > 3) begin : g_bad_params
    $error("maze_move_sequencer: illegal parameter combination");
  end

  state_e      state_q, state_d;
  logic [5:0]  tgt_q, tgt_d;
  logic [5:0]  src_q, src_d;
  logic        fail_q, fail_d;
  logic [31:0] dwell_q, dwell_d;
  logic [7:0]  angle1_q, angle1_d, angle2_q, angle2_d;
  logic [7:0]  angle3_q, angle3_d, angle4_q, angle4_d;
`ifdef MOVE_RETRY_EN
  logic [1:0]  retry_q, retry_d;
`endif

  dir_e        dir;
  logic [5:0]  src_col;

  assign src_col = 6'(32'(src_q) % COLS);

  // Decode the move direction from source and target; DIR_NONE marks an illegal move.
  always_comb begin
    dir = DIR_NONE;
    if ((32'(src_q) < NUM_CELLS) && (32'(tgt_q) < NUM_CELLS)) begin
      if (({1'b0, tgt_q} == {1'b0, src_q} + 7'd1) && (src_col != LAST_COL)) begin
        dir = DIR_E;
      end else if (({1'b0, src_q} == {1'b0, tgt_q} + 7'd1) && (src_col != 6'd0)) begin
        dir = DIR_W;
      end else if ({1'b0, tgt_q} == {1'b0, src_q} + COLS_W) begin
        dir = DIR_S;
      end else if ({1'b0, src_q} == {1'b0, tgt_q} + COLS_W) begin
        dir = DIR_N;
      end
    end
  end

  // Next-state, dwell timing and servo targets for the move sequence.
  always_comb begin
    // NOTE: every _d gets its hold value first so no path through the case infers a latch.
    state_d  = state_q;
    tgt_d    = tgt_q;
    src_d    = src_q;
    fail_d   = fail_q;
    angle1_d = angle1_q;
    angle2_d = angle2_q;
    angle3_d = angle3_q;
    angle4_d = angle4_q;
    dwell_d  = (state_q == S_TILT || state_q == S_LEVEL) ? dwell_q + 32'd1 : 32'd0;
`ifdef MOVE_RETRY_EN
    retry_d  = retry_q;
`endif

    unique case (state_q)
      S_IDLE: begin
`ifdef MOVE_RETRY_EN
        retry_d = 2'd0;
`endif
        if (move_req) begin
          tgt_d   = next_state;
          src_d   = maze_state;
          fail_d  = 1'b0;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        state_d = S_TILT;
        unique case (dir)
          DIR_E: begin angle1_d = ANG_HI;  angle2_d = ANG_LO;  angle3_d = ANG_MID; angle4_d = ANG_MID; end
          DIR_W: begin angle1_d = ANG_LO;  angle2_d = ANG_HI;  angle3_d = ANG_MID; angle4_d = ANG_MID; end
          DIR_S: begin angle1_d = ANG_MID; angle2_d = ANG_MID; angle3_d = ANG_HI;  angle4_d = ANG_LO;  end
          DIR_N: begin angle1_d = ANG_MID; angle2_d = ANG_MID; angle3_d = ANG_LO;  angle4_d = ANG_HI;  end
          default: begin
            fail_d  = 1'b1;
            state_d = S_DONE;
          end
        endcase
      end
      S_TILT: begin
        if (dwell_q == TILT_LAST) begin
          angle1_d = ANG_MID;
          angle2_d = ANG_MID;
          angle3_d = ANG_MID;
          angle4_d = ANG_MID;
          state_d  = S_LEVEL;
        end
      end
      S_LEVEL: begin
        if (dwell_q == SETTLE_LAST) state_d = S_VERIFY;
      end
      S_VERIFY: begin
        if (maze_state == tgt_q) begin
          fail_d  = 1'b0;
          state_d = S_DONE;
        end
`ifdef MOVE_RETRY_EN
        else if (32'(retry_q) < MAX_RETRY) begin
          retry_d = retry_q + 2'd1;
          src_d   = maze_state;
          state_d = S_CHECK;
        end
`endif
        else begin
          fail_d  = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (state_d != state_q) dwell_d = 32'd0;
  end

  // State register; reset parks the servos level straight away.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      tgt_q    <= 6'd0;
      src_q    <= 6'd0;
      fail_q   <= 1'b0;
      dwell_q  <= 32'd0;
      angle1_q <= ANG_MID;
      angle2_q <= ANG_MID;
      angle3_q <= ANG_MID;
      angle4_q <= ANG_MID;
`ifdef MOVE_RETRY_EN
      retry_q  <= 2'd0;
`endif
    end else begin
      // NOTE: non-blocking updates so every register samples pre-edge values.
      state_q  <= state_d;
      tgt_q    <= tgt_d;
      src_q    <= src_d;
      fail_q   <= fail_d;
      dwell_q  <= dwell_d;
      angle1_q <= angle1_d;
      angle2_q <= angle2_d;
      angle3_q <= angle3_d;
      angle4_q <= angle4_d;
`ifdef MOVE_RETRY_EN
      retry_q  <= retry_d;
`endif
    end
  end

  assign angle1        = angle1_q;
  assign angle2        = angle2_q;
  assign angle3        = angle3_q;
  assign angle4        = angle4_q;
  assign busy          = (state_q != S_IDLE);
  assign move_complete = (state_q == S_DONE);
  assign move_fail     = (state_q == S_DONE) && fail_q;

endmodule

// File: tb/tb_maze_move_sequencer.sv
// tb_maze_move_sequencer
// A move-level reference model expands each accepted request into the
// per-cycle output vectors the sequencer must show. One compare process
// checks the DUT against that timeline on every cycle. Literal expectations
// for latency, angles and tilt counts pin the model on directed moves.
module tb_maze_move_sequencer;

  localparam int COLS      = 6;
  localparam int NUM_CELLS = 36;
  localparam int NEUT      = 90;
  localparam int DELTA     = 20;
  localparam int TILT      = 10;
  localparam int SETTLE    = 5;
  localparam int MAX_RETRY = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       move_req = 1'b0;
  logic [5:0] next_state = 6'd0;
  logic [5:0] maze_state = 6'd0;
  logic [7:0] angle1, angle2, angle3, angle4;
  logic       busy, move_complete, move_fail;

  maze_move_sequencer #(
    .COLS(COLS), .NUM_CELLS(NUM_CELLS), .NEUTRAL(NEUT), .TILT_DELTA(DELTA),
    .TILT_CYCLES(TILT), .SETTLE_CYCLES(SETTLE), .MAX_RETRY(MAX_RETRY)
  ) dut (
    .clk(clk), .rst(rst), .move_req(move_req), .next_state(next_state),
    .maze_state(maze_state), .angle1(angle1), .angle2(angle2), .angle3(angle3),
    .angle4(angle4), .busy(busy), .move_complete(move_complete), .move_fail(move_fail)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] a1, a2, a3, a4;
    logic       busy, mc, mf;
  } out_t;

  out_t exp_q[$];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Written only by the compare process.
  int          n_cmp = 0, n_fail = 0;
  int          tilt_phases = 0, tilt_cycles = 0, mc_cyc = -1, lit_ack = 0;
  logic        mc_fail = 1'b0, in_tilt = 1'b0;
  logic [31:0] seen_ang = 32'd0;
  // Written only by the stimulus process.
  int          accept_cyc = 0, base_phases = 0, base_cycles = 0, lit_req = 0, lit_sel = 0;
  string       lit_name = "";
  logic [63:0] lit_exp = 64'd0;

  function automatic out_t mk(int a1, int a2, int a3, int a4, bit b, bit c, bit f);
    out_t o;
    o.a1 = 8'(a1); o.a2 = 8'(a2); o.a3 = 8'(a3); o.a4 = 8'(a4);
    o.busy = b; o.mc = c; o.mf = f;
    return o;
  endfunction

  // Direction rules: 0 East, 1 West, 2 South, 3 North, -1 illegal.
  function automatic int dir_of(int s, int t);
    if (s >= NUM_CELLS || t >= NUM_CELLS) return -1;
    if (t - s == 1 && s % COLS != COLS - 1) return 0;
    if (t - s == -1 && s % COLS != 0) return 1;
    if (t - s == COLS) return 2;
    if (t - s == -COLS) return 3;
    return -1;
  endfunction

  function automatic out_t tilt_out(int d);
    case (d)
      0:       return mk(NEUT + DELTA, NEUT - DELTA, NEUT, NEUT, 1, 0, 0);
      1:       return mk(NEUT - DELTA, NEUT + DELTA, NEUT, NEUT, 1, 0, 0);
      2:       return mk(NEUT, NEUT, NEUT + DELTA, NEUT - DELTA, 1, 0, 0);
      default: return mk(NEUT, NEUT, NEUT - DELTA, NEUT + DELTA, 1, 0, 0);
    endcase
  endfunction

  function automatic logic [5:0] rnd6();
    return 6'($urandom_range(0, 63));
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h at t=%0t", name, act, req, $time);
    end
  endtask

  // Compare process: one timeline check per cycle, plus literal checks on request.
  out_t        e_cur, a_cur;
  logic        tilt_now;
  logic [63:0] lit_act;
  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) e_cur = exp_q.pop_front();
      else                   e_cur = mk(NEUT, NEUT, NEUT, NEUT, 0, 0, 0);
      a_cur = {angle1, angle2, angle3, angle4, busy, move_complete, move_fail};
      check("outputs", 64'(a_cur), 64'(e_cur));
      tilt_now = (angle1 != 8'(NEUT)) || (angle2 != 8'(NEUT)) ||
                 (angle3 != 8'(NEUT)) || (angle4 != 8'(NEUT));
      if (tilt_now) begin
        tilt_cycles++;
        if (!in_tilt) begin
          tilt_phases++;
          seen_ang = {angle1, angle2, angle3, angle4};
        end
      end
      in_tilt = tilt_now;
      if (move_complete) begin
        mc_cyc  = cyc;
        mc_fail = move_fail;
      end
      if (lit_req != lit_ack) begin
        case (lit_sel)
          0:       lit_act = 64'(mc_cyc - accept_cyc + 1);
          1:       lit_act = 64'(mc_fail);
          2:       lit_act = 64'(tilt_phases - base_phases);
          3:       lit_act = 64'(seen_ang);
          4:       lit_act = 64'(tilt_cycles - base_cycles);
          5:       lit_act = 64'(mc_cyc >= accept_cyc);
          default: lit_act = 64'(a_cur);
        endcase
        check(lit_name, lit_act, lit_exp);
        lit_ack = lit_req;
      end
    end
  end

  // Ask the compare process for one literal check and wait for it (bounded).
  task automatic lit_check(input string name, input int sel, input logic [63:0] v);
    lit_name = name; lit_sel = sel; lit_exp = v; lit_req++;
    for (int k = 0; k < 4 && lit_ack != lit_req; k++) begin
      @(negedge clk); #1;
    end
    if (lit_ack != lit_req) begin
      $display("FAIL lit_handshake: ack=%0d required=%0d", lit_ack, lit_req);
      $fatal(1, "literal check handshake stalled");
    end
    @(posedge clk); #1;
  endtask

  // Issue one request; the model expands it into expected outputs per cycle.
  // s0..s2: cell sensed at each VERIFY. abort_at >= 0 resets mid-move.
  task automatic run_move(input logic [5:0] src, input logic [5:0] tgt,
                          input logic [5:0] s0, input logic [5:0] s1, input logic [5:0] s2,
                          input bit noise, input bit hold_end, input int abort_at);
    out_t       tl[$];
    logic [5:0] dv[$];
    logic [5:0] sensed [3];
    int         cur, att, d;
    sensed = '{s0, s1, s2};
    cur = int'(src);
    att = 0;
    for (int guard = 0; guard < 8; guard++) begin
      tl.push_back(mk(NEUT, NEUT, NEUT, NEUT, 1, 0, 0)); dv.push_back(rnd6());
      d = dir_of(cur, int'(tgt));
      if (d < 0) begin
        tl.push_back(mk(NEUT, NEUT, NEUT, NEUT, 1, 1, 1)); dv.push_back(rnd6());
        break;
      end
      repeat (TILT)   begin tl.push_back(tilt_out(d)); dv.push_back(rnd6()); end
      repeat (SETTLE) begin tl.push_back(mk(NEUT, NEUT, NEUT, NEUT, 1, 0, 0)); dv.push_back(rnd6()); end
      tl.push_back(mk(NEUT, NEUT, NEUT, NEUT, 1, 0, 0)); dv.push_back(sensed[att]);
      if (sensed[att] == tgt) begin
        tl.push_back(mk(NEUT, NEUT, NEUT, NEUT, 1, 1, 0)); dv.push_back(rnd6());
        break;
      end
`ifdef MOVE_RETRY_EN
      if (att < MAX_RETRY) begin
        cur = int'(sensed[att]);
        att++;
        continue;
      end
`endif
      tl.push_back(mk(NEUT, NEUT, NEUT, NEUT, 1, 1, 1)); dv.push_back(rnd6());
      break;
    end

    move_req = 1'b1; next_state = tgt; maze_state = src;
    @(posedge clk); #1;
    accept_cyc  = cyc;
    base_phases = tilt_phases;
    base_cycles = tilt_cycles;
    foreach (tl[i]) exp_q.push_back(tl[i]);
    for (int i = 0; i < tl.size(); i++) begin
      if (i == abort_at) begin
        move_req = 1'b0;
        #2;
        exp_q.delete();
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        return;
      end
      move_req   = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      next_state = rnd6();
      maze_state = dv[i];
      if (hold_end && i == tl.size() - 1) move_req = 1'b1;
      @(posedge clk); #1;
    end
    if (!hold_end) move_req = 1'b0;
  endtask

  logic [5:0] r_src, r_tgt, r_s [3];

  initial begin
    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    lit_check("reset_outputs", 7, 64'(mk(90, 90, 90, 90, 0, 0, 0)));
    rst = 1'b1;
    @(posedge clk); #1;

    // East 7 -> 8, ball arrives.
    run_move(6'd7, 6'd8, 6'd8, 6'd8, 6'd8, 1'b0, 1'b0, -1);
    lit_check("east_latency", 0, 64'd18);
    lit_check("east_fail", 1, 64'd0);
    lit_check("east_angles", 3, 64'({8'd110, 8'd70, 8'd90, 8'd90}));
    lit_check("east_tilt_cycles", 4, 64'd10);

    // Illegal moves: row wrap, same cell, out of range.
    run_move(6'd5, 6'd6, 6'd6, 6'd6, 6'd6, 1'b0, 1'b0, -1);
    lit_check("wrap_latency", 0, 64'd2);
    lit_check("wrap_fail", 1, 64'd1);
    lit_check("wrap_no_tilt", 2, 64'd0);
    run_move(6'd7, 6'd7, 6'd7, 6'd7, 6'd7, 1'b0, 1'b0, -1);
    lit_check("same_fail", 1, 64'd1);
    run_move(6'd3, 6'd40, 6'd40, 6'd40, 6'd40, 1'b0, 1'b0, -1);
    lit_check("range_latency", 0, 64'd2);
    lit_check("range_no_tilt", 2, 64'd0);

    // North 14 -> 8.
    run_move(6'd14, 6'd8, 6'd8, 6'd8, 6'd8, 1'b0, 1'b0, -1);
    lit_check("north_angles", 3, 64'({8'd90, 8'd90, 8'd70, 8'd110}));
    lit_check("north_fail", 1, 64'd0);

    // Miss: ball stays at the source.
    run_move(6'd7, 6'd8, 6'd7, 6'd7, 6'd7, 1'b0, 1'b0, -1);
    lit_check("miss_fail", 1, 64'd1);
`ifdef MOVE_RETRY_EN
    lit_check("miss_phases", 2, 64'd3);
    lit_check("miss_latency", 0, 64'd52);
`else
    lit_check("miss_phases", 2, 64'd1);
    lit_check("miss_latency", 0, 64'd18);
`endif

    // Requests while busy are ignored.
    run_move(6'd20, 6'd21, 6'd21, 6'd21, 6'd21, 1'b1, 1'b0, -1);
    lit_check("busy_req_latency", 0, 64'd18);
    lit_check("busy_req_fail", 1, 64'd0);

    // Reset during TILT, then a normal move.
    run_move(6'd7, 6'd8, 6'd8, 6'd8, 6'd8, 1'b0, 1'b0, 5);
    lit_check("abort_no_complete", 5, 64'd0);
    lit_check("abort_phases", 2, 64'd1);
    run_move(6'd8, 6'd9, 6'd9, 6'd9, 6'd9, 1'b0, 1'b0, -1);
    lit_check("after_reset_fail", 1, 64'd0);

    // Randomised moves, some back to back with move_req held across DONE.
    for (int n = 0; n < 40; n++) begin
      r_src = 6'($urandom_range(0, 40));
      case ($urandom_range(0, 5))
        0:       r_tgt = r_src + 6'd1;
        1:       r_tgt = r_src - 6'd1;
        2:       r_tgt = r_src + 6'd6;
        3:       r_tgt = r_src - 6'd6;
        4:       r_tgt = r_src;
        default: r_tgt = rnd6();
      endcase
      for (int k = 0; k < 3; k++) begin
        case ($urandom_range(0, 3))
          0, 1:    r_s[k] = r_tgt;
          2:       r_s[k] = r_src;
          default: r_s[k] = r_tgt + 6'd1;
        endcase
      end
      run_move(r_src, r_tgt, r_s[0], r_s[1], r_s[2], 1'b1, (n % 4) == 0, -1);
    end
    move_req = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/maze_move_sequencer.md
# maze_move_sequencer

Sequences one maze move at a time for the tilt-maze robot. It takes a requested next cell from the Q-learning exploit stage and drives the four servo angle targets through a tilt, hold, level and settle sequence. It then checks the sensed cell against the target and returns a completion/fail handshake. It sits between the exploit logic and the PWM servo controller, and owns the servo angle buses during autonomous runs.

## Interface
- `COLS`, default 6: maze columns; cell = row*COLS + col.
- `NUM_CELLS`, default 36: valid cells are 0..NUM_CELLS-1.
- `NEUTRAL`, default 90: level servo angle, in degrees.
- `TILT_DELTA`, default 20: tilt offset in degrees; NEUTRAL+TILT_DELTA ≤ 180 and NEUTRAL ≥ TILT_DELTA.
- `TILT_CYCLES`, default 25_000_000: cycles the tilt is held.
- `SETTLE_CYCLES`, default 12_500_000: cycles spent level before verify.
- `MAX_RETRY`, default 2: retries per move (used only with MOVE_RETRY_EN).
- `clk` in 1: system clock.
- `rst` in 1: asynchronous, active-low reset.
- `move_req` in 1: request strobe; sampled only in IDLE.
- `next_state` in 6: target cell, captured with move_req.
- `maze_state` in 6: sensed current cell.
- `angle1`, `angle2` out 8 each: X-axis servo pair.
- `angle3`, `angle4` out 8 each: Y-axis servo pair.
- `busy` out 1: high in every state except IDLE.
- `move_complete` out 1: one-cycle pulse ending every accepted request.
- `move_fail` out 1: qualifies move_complete; 1 means the move was rejected or missed its target.

## Operation
- FSM states: IDLE, CHECK, TILT, LEVEL, VERIFY, DONE.
- IDLE: when move_req=1, the block latches `tgt`=next_state and `src`=maze_state, then goes to CHECK. move_req is ignored in all other states.
- CHECK decodes the direction from the difference tgt−src:
  - +1 = East, only if src%COLS ≠ COLS−1.
  - −1 = West, only if src%COLS ≠ 0.
  - +COLS = South.
  - −COLS = North.
  - The move is valid only if src and tgt are both < NUM_CELLS. Anything else (same cell, row wrap, non-adjacent, out of range) is invalid.
  - Valid → TILT. Invalid → DONE with fail=1; angles are not touched.
- TILT: angles are set on the entry edge.
  - East: angle1=NEUTRAL+D, angle2=NEUTRAL−D.
  - West: angle1=NEUTRAL−D, angle2=NEUTRAL+D.
  - South: angle3=NEUTRAL+D, angle4=NEUTRAL−D.
  - North: angle3=NEUTRAL−D, angle4=NEUTRAL+D.
  - The pair not in use stays at NEUTRAL.
  - Hold for TILT_CYCLES, then go to LEVEL.
- LEVEL: all four angles are set to NEUTRAL on entry. Wait SETTLE_CYCLES, then go to VERIFY.
- VERIFY, one cycle: maze_state==tgt → DONE with fail=0. Mismatch → see Configuration.
- DONE, one cycle: move_complete=1 and move_fail=fail, then IDLE.
- Counters: one 32-bit dwell counter shared by TILT and LEVEL, cleared on every state entry; 2-bit retry counter.
- Angle arithmetic is unsigned 8-bit. The parameter constraints above guarantee no wrap.

## Timing
- Reset (rst=0, async): IDLE; all angles = NEUTRAL; busy, move_complete, move_fail, counters = 0.
- Reset asserted mid-move forces the angles to NEUTRAL immediately, with no completion pulse.
- move_req accepted at edge N: busy=1 from N+1 and CHECK at N+1.
- Invalid move: move_complete at N+2 (DONE), busy=0 at N+3.
- Valid move:
  - TILT entered at N+2.
  - LEVEL at N+2+TILT_CYCLES.
  - VERIFY at N+2+TILT_CYCLES+SETTLE_CYCLES.
  - DONE one cycle later; total latency TILT_CYCLES+SETTLE_CYCLES+3 cycles to the move_complete pulse.
- move_req held high across DONE→IDLE is accepted again on the first IDLE cycle; there is no edge detect.
- maze_state changes outside VERIFY have no effect.

## Configuration
- `MOVE_RETRY_EN` defined:
  - On a VERIFY mismatch with retry count < MAX_RETRY: increment the count, recompute the direction from tgt and the current maze_state, and go to CHECK. A maze_state that is now non-adjacent fails in CHECK.
  - At MAX_RETRY: go to DONE with fail=1.
  - The retry count clears in IDLE.
- Not defined: any VERIFY mismatch → DONE with fail=1. No retry logic or retry counter is synthesised.

## Test plan
- Reset: assert rst=0 mid-TILT → angles=90/90/90/90, busy=0, no move_complete; release rst → move_req accepted normally.
- East move, src=7, tgt=8, maze_state→8 during LEVEL (small TILT/SETTLE params, e.g. 10/5) → angle1=110, angle2=70 for 10 cycles, then level; move_complete with move_fail=0 at cycle N+18.
- Invalid moves: src=5→tgt=6 (row wrap), 7→7, 3→40 → move_complete with move_fail=1 at N+2; angles never leave 90.
- North move, src=14, tgt=8 → angle3=70, angle4=110; angle1/angle2 stay 90.
- Miss: maze_state stays at src. Without MOVE_RETRY_EN → fail=1 after one attempt. With MOVE_RETRY_EN, MAX_RETRY=2 → three tilt phases, then fail=1.
- move_req pulsed while busy with a different next_state → ignored; the original tgt completes unchanged.
